axis_stall_injector: RTL and testbench

AXIS_STALL_INJECTOR -- requirements
Module: axis_stall_injector

---
 rtl/axis_stall_injector.sv | 88 ++++++++
 tb/tb_axis_stall_injector.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stall_injector.sv
// Two-entry stream buffer between a DUT output and a stream checker that injects
// pseudo-random stalls on both sides. Latency 1 cycle minimum; upstream stalls when full or on in_stall.
module axis_stall_injector #(
  parameter int          DATA_WIDTH          = 10,
  parameter int          IN_STALL_THRESHOLD  = 0,
  parameter int          OUT_STALL_THRESHOLD = 0,
  parameter logic [15:0] IN_SEED             = 16'hACE1,
  parameter logic [15:0] OUT_SEED            = 16'h1D2B
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_valid,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  input_ready,
  output logic                  output_valid,
  output logic [DATA_WIDTH-1:0] output_data,
  input  logic                  output_ready,
  output logic [31:0]           transfer_count
);

  // x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
  localparam logic [15:0] POLY    = 16'hB400;
  localparam logic [8:0]  IN_THR  = 9'(IN_STALL_THRESHOLD);
  localparam logic [8:0]  OUT_THR = 9'(OUT_STALL_THRESHOLD);

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 16'h0000);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic [31:0]           transfer_count_q, transfer_count_d;
  logic [15:0]           lfsr_in_q, lfsr_in_d;
  logic [15:0]           lfsr_out_q, lfsr_out_d;
  logic                  in_stall, out_stall;
  logic                  wr_en, rd_en;

  // Stalls depend only on registered LFSR state, so no input-to-output combinational path.
  assign in_stall  = {1'b0, lfsr_in_q[7:0]}  < IN_THR;
  assign out_stall = {1'b0, lfsr_out_q[7:0]} < OUT_THR;

  assign input_ready    = !rst && (occ_q < 2'd2) && !in_stall;
  assign output_valid   = (occ_q != 2'd0) && !out_stall;
  assign output_data    = mem_q[rd_ptr_q];
  assign transfer_count = transfer_count_q;

  always_comb begin
    wr_en            = input_valid && input_ready;
    rd_en            = output_valid && output_ready;
    wr_ptr_d         = wr_ptr_q ^ wr_en;
    rd_ptr_d         = rd_ptr_q ^ rd_en;
    occ_d            = occ_q;
    if (wr_en && !rd_en)      occ_d = occ_q + 2'd1;
    else if (rd_en && !wr_en) occ_d = occ_q - 2'd1;
    mem_d            = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = input_data;
    transfer_count_d = transfer_count_q + 32'(rd_en);
    lfsr_in_d        = lfsr_step(lfsr_in_q);
    lfsr_out_d       = lfsr_step(lfsr_out_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      occ_q            <= 2'd0;
      transfer_count_q <= 32'd0;
      lfsr_in_q        <= IN_SEED;
      lfsr_out_q       <= OUT_SEED;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      occ_q            <= occ_d;
      transfer_count_q <= transfer_count_d;
      lfsr_in_q        <= lfsr_in_d;
      lfsr_out_q       <= lfsr_out_d;
    end
  end

  // Storage is deliberately left out of reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_axis_stall_injector.sv
// Randomized bench for axis_stall_injector: a queue-based reference model predicts
// ready/valid/data each cycle for three parameterizations sharing one clock and reset.
module tb_axis_stall_injector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv   [3];
  logic [9:0] id   [3];
  logic       ordy [3];
  logic       ir   [3];
  logic       ov   [3];
  logic [9:0] od   [3];
  logic [31:0] tc  [3];

  always #5 clk = ~clk;

  axis_stall_injector #(.DATA_WIDTH(10), .IN_STALL_THRESHOLD(0), .OUT_STALL_THRESHOLD(0)) dut0 (
    .clk(clk), .rst(rst), .input_valid(iv[0]), .input_data(id[0]), .input_ready(ir[0]),
    .output_valid(ov[0]), .output_data(od[0]), .output_ready(ordy[0]), .transfer_count(tc[0]));
  axis_stall_injector #(.DATA_WIDTH(10), .IN_STALL_THRESHOLD(128), .OUT_STALL_THRESHOLD(128)) dut1 (
    .clk(clk), .rst(rst), .input_valid(iv[1]), .input_data(id[1]), .input_ready(ir[1]),
    .output_valid(ov[1]), .output_data(od[1]), .output_ready(ordy[1]), .transfer_count(tc[1]));
  axis_stall_injector #(.DATA_WIDTH(10), .IN_STALL_THRESHOLD(0), .OUT_STALL_THRESHOLD(256)) dut2 (
    .clk(clk), .rst(rst), .input_valid(iv[2]), .input_data(id[2]), .input_ready(ir[2]),
    .output_valid(ov[2]), .output_data(od[2]), .output_ready(ordy[2]), .transfer_count(tc[2]));

  int thr_in [3];
  int thr_out[3];
  int vectors = 0;
  int errors  = 0;

  // Reference model: buffered words, stall generators, handshake count.
  logic [9:0]  mq[$];
  logic [15:0] m_lin, m_lout;
  logic [31:0] m_cnt;
  logic        m_hs_in, m_hs_out;
  logic        exp_ir, exp_ov, obs_ir, obs_ov;
  logic [9:0]  exp_od, obs_od;
  logic [11:0] exp_vec, obs_vec;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic [15:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  task automatic do_reset();
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; id[k] = '0; ordy[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mq.delete();
    m_lin  = 16'hACE1;
    m_lout = 16'h1D2B;
    m_cnt  = 32'd0;
  endtask

  // Drives one cycle on instance k, records prediction and observation, advances the model.
  task automatic cycle(input int k, input logic v, input logic [9:0] d, input logic r);
    iv[k] = v; id[k] = d; ordy[k] = r;
    #1;
    exp_ir   = (mq.size() < 2) && !(int'(m_lin[7:0]) < thr_in[k]);
    exp_ov   = (mq.size() > 0) && !(int'(m_lout[7:0]) < thr_out[k]);
    exp_od   = (mq.size() > 0) ? mq[0] : 10'h000;
    obs_ir   = ir[k];
    obs_ov   = ov[k];
    obs_od   = od[k];
    exp_vec  = {exp_ir, exp_ov, exp_ov ? exp_od : 10'h000};
    obs_vec  = {obs_ir, obs_ov, exp_ov ? obs_od : 10'h000};
    m_hs_in  = v && exp_ir;
    m_hs_out = exp_ov && r;
    if (m_hs_out) begin
      void'(mq.pop_front());
      m_cnt = m_cnt + 32'd1;
    end
    if (m_hs_in) mq.push_back(d);
    m_lin  = lfsr_adv(m_lin);
    m_lout = lfsr_adv(m_lout);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin iv[k] = 1'b1; ordy[k] = 1'b1; end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({ir[k], ov[k], tc[k]} !== {1'b0, 1'b0, 32'd0}) begin
        errors++;
        $display("FAIL reset dut%0d: ir=%b ov=%b tc=%0d, want 0/0/0", k, ir[k], ov[k], tc[k]);
      end
    end
    do_reset();
    cycle(0, 1'b1, 10'h2A5, 1'b0);
    vectors++;
    if (obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    do_reset();
    for (int c = 0; c <= 100; c++) begin
      cycle(0, sent < 100, 10'(sent), 1'b1);
      if (m_hs_in) sent++;
      vectors++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL stream cyc %0d: got %h want %h", c, obs_vec, exp_vec);
      end
      if (c >= 1) begin
        vectors++;
        if (obs_ov !== 1'b1 || obs_od !== 10'(c - 1)) begin
          errors++;
          $display("FAIL stream_rate cyc %0d: ov=%b od=%0d want 1/%0d", c, obs_ov, obs_od, c - 1);
        end
      end
    end
    vectors++;
    if (tc[0] !== 32'd100) begin
      errors++;
      $display("FAIL stream_count: got %0d want 100", tc[0]);
    end
  endtask

  task automatic test_random_stalls();
    int sent = 0;
    int cyc  = 0;
    do_reset();
    while (m_cnt < 1000 && cyc < 20000) begin
      cycle(1, (sent < 1000) && ($urandom_range(0, 3) != 0), 10'(sent), $urandom_range(0, 3) != 0);
      if (m_hs_in) sent++;
      cyc++;
      vectors++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (tc[1] !== 32'd1000) begin
      errors++;
      $display("FAIL random_count: got %0d want 1000 (model %0d, %0d cycles)", tc[1], m_cnt, cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] got[$];
    logic [9:0] w = 10'd1;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      cycle(0, 1'b1, w, 1'b0);
      if (m_hs_in) w++;
      vectors++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL bp_fill cyc %0d: got %h want %h", c, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (obs_ir !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: input_ready=%b want 0", obs_ir);
    end
    for (int c = 0; c < 8; c++) begin
      cycle(0, w <= 10'd3, w, 1'b1);
      if (m_hs_in) w++;
      if (obs_ov) got.push_back(obs_od);
      vectors++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL bp_drain cyc %0d: got %h want %h", c, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (got.size() != 3 || got[0] !== 10'd1 || got[1] !== 10'd2 || got[2] !== 10'd3) begin
      errors++;
      $display("FAIL bp_order: got %0d words, first=%0d, want 3 words 1,2,3", got.size(),
               got.size() > 0 ? got[0] : 10'h3FF);
    end
  endtask

  task automatic test_out_stall_full();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cycle(2, 1'b1, 10'(c + 7), 1'b1);
      vectors++;
      if (obs_vec !== exp_vec || obs_ov !== 1'b0) begin
        errors++;
        $display("FAIL out_stall cyc %0d: got %h want %h", c, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (dut2.occ_q !== 2'd2 || ir[2] !== 1'b0) begin
      errors++;
      $display("FAIL out_stall_occ: occ=%0d ir=%b want 2/0", dut2.occ_q, ir[2]);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    cycle(0, 1'b1, 10'h011, 1'b1);
    cycle(0, 1'b0, 10'h000, 1'b1);
    cycle(0, 1'b1, 10'h022, 1'b0);
    cycle(0, 1'b1, 10'h033, 1'b0);
    vectors++;
    if (ov[0] !== 1'b1 || tc[0] !== 32'd1) begin
      errors++;
      $display("FAIL mid_pre: ov=%b tc=%0d want 1/1", ov[0], tc[0]);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({ov[0], ir[0], tc[0]} !== {1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL mid_async: ov=%b ir=%b tc=%0d want 0/0/0", ov[0], ir[0], tc[0]);
    end
    do_reset();
    cycle(0, 1'b1, 10'h155, 1'b1);
    cycle(0, 1'b0, 10'h000, 1'b1);
    vectors++;
    if (obs_vec !== exp_vec || obs_ov !== 1'b1 || obs_od !== 10'h155) begin
      errors++;
      $display("FAIL mid_first_word: ov=%b od=%h want 1/155", obs_ov, obs_od);
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    force dut0.transfer_count_d = 32'hFFFF_FFFF;
    cycle(0, 1'b0, 10'h000, 1'b0);
    release dut0.transfer_count_d;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    vectors++;
    if (tc[0] !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %h want ffffffff", tc[0]);
    end
    cycle(0, 1'b1, 10'h2AA, 1'b1);
    cycle(0, 1'b0, 10'h000, 1'b1);
    #1;
    vectors++;
    if (tc[0] !== m_cnt || tc[0] !== 32'd0) begin
      errors++;
      $display("FAIL wrap: got %h want 00000000", tc[0]);
    end
  endtask

  initial begin
    thr_in[0] = 0;   thr_out[0] = 0;
    thr_in[1] = 128; thr_out[1] = 128;
    thr_in[2] = 0;   thr_out[2] = 256;
    for (int k = 0; k < 3; k++) begin iv[k] = 1'b0; id[k] = '0; ordy[k] = 1'b0; end
    @(negedge clk);
    test_reset();
    test_stream();
    test_random_stalls();
    test_backpressure();
    test_out_stall_full();
    test_reset_midstream();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
